// File: rtl/sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_mem_arbiter
//
// Purpose:
//   Shares one single-port sprite/tile memory between two requesters on the
//   pixel clock:
//     port 0 - pixel fetch from the colour mapper (read only, latency critical)
//     port 1 - tile/map loader (read/write, bulk traffic)
//   At most one access is issued per cycle. Each issued access pushes a
//   {valid, port} tag into a pipe that tracks the memory read latency, so the
//   returned data can be steered to the port that issued the read.
//   Priority depends on a registered mode:
//     VIDEO - visible region, port 0 first
//     BLANK - blanking interval, port 1 first
//     FORCE - port 1 has waited MAX_WAIT cycles and wins unconditionally
//
// Ports:
//   Clk, Reset_n          pixel clock, synchronous active-low reset
//   active_video          1 = visible region, 0 = blanking
//   p0_req/p0_addr        port 0 read request (held until granted)
//   p0_gnt                port 0 granted this cycle (combinational)
//   p0_rvalid/p0_rdata    port 0 read return
//   p1_req/p1_we/p1_addr/p1_wdata
//                         port 1 request (held until granted)
//   p1_gnt                port 1 granted this cycle (combinational)
//   p1_rvalid/p1_rdata    port 1 read return
//   mem_addr/mem_we/mem_wdata
//                         registered command to the memory macro
//   mem_rdata             memory read data, valid READ_LAT cycles after the
//                         address is presented
//   p0_miss_cnt           saturating count of cycles port 0 waited
// -----------------------------------------------------------------------------
module sprite_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              active_video,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       p0_miss_cnt
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    MODE_VIDEO = 2'd0,
    MODE_BLANK = 2'd1,
    MODE_FORCE = 2'd2
  } mode_t;

  mode_t             mode_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;

  // Tag pipe: stage 0 lines up with the cycle mem_addr is presented, stage
  // READ_LAT with the cycle mem_rdata is valid for that access.
  logic [READ_LAT:0] tag_valid_reg;
  logic [READ_LAT:0] tag_port_reg;

  logic issue_read;
  logic ret_valid;

  // ---------------------------------------------------------------------------
  // Grant. Only the registered mode decides the order, so a change of
  // active_video takes effect one cycle later. Nothing is granted in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (Reset_n) begin
      if (mode_reg == MODE_VIDEO) begin
        p0_gnt = p0_req;
        p1_gnt = p1_req & ~p0_req;
      end else begin
        // BLANK and FORCE both put port 1 first.
        p1_gnt = p1_req;
        p0_gnt = p0_req & ~p1_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port 1 starvation counter: counts cycles port 1 is left waiting and
  // saturates at MAX_WAIT; any cycle without a waiting port 1 clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_next = '0;
    if (p1_req && !p1_gnt) begin
      if (wait_cnt_reg == WAIT_SAT) begin
        wait_cnt_next = wait_cnt_reg;
      end else begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM. Deriving the mode from the next wait count means FORCE is
  // entered in the cycle right after the counter saturates and is left in the
  // cycle right after port 1 is served (the counter clears on its grant).
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mode_reg     <= MODE_VIDEO;
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_next == WAIT_SAT) begin
        mode_reg <= MODE_FORCE;
      end else if (active_video) begin
        mode_reg <= MODE_VIDEO;
      end else begin
        mode_reg <= MODE_BLANK;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command register. Address and write data hold on idle cycles so
  // the macro sees a stable bus; only the write enable drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= p1_gnt & p1_we;
      if (p0_gnt) begin
        mem_addr <= p0_addr;
      end else if (p1_gnt) begin
        mem_addr  <= p1_addr;
        mem_wdata <= p1_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipe. Writes and idle cycles push an invalid tag so the pipe
  // shifts every cycle and returns stay aligned with issue order. Reset
  // empties it, which silently drops any reads still in flight.
  // ---------------------------------------------------------------------------
  assign issue_read = p0_gnt | (p1_gnt & ~p1_we);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      tag_valid_reg <= '0;
      tag_port_reg  <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[READ_LAT-1:0], issue_read};
      tag_port_reg  <= {tag_port_reg[READ_LAT-1:0], p1_gnt};
    end
  end

  // Return routing. Data is gated so an idle port never shows stale bytes,
  // and the return is masked while reset is held.
  assign ret_valid = tag_valid_reg[READ_LAT] & Reset_n;
  assign p0_rvalid = ret_valid & ~tag_port_reg[READ_LAT];
  assign p1_rvalid = ret_valid &  tag_port_reg[READ_LAT];
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Port 0 miss counter: cleared only by reset, sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      p0_miss_cnt <= '0;
    end else if (p0_req && !p0_gnt && (p0_miss_cnt != 16'hFFFF)) begin
      p0_miss_cnt <= p0_miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
module tb_sprite_mem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 2;
  localparam int MAX_WAIT = 64;

  logic              Clk;
  logic              Reset_n;
  logic              active_video;
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       p0_miss_cnt;

  sprite_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .active_video(active_video),
    .p0_req      (p0_req),
    .p0_addr     (p0_addr),
    .p0_gnt      (p0_gnt),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_gnt      (p1_gnt),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .p0_miss_cnt (p0_miss_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  // Memory macro: write on the edge, READ_LAT cycles from address to data.
  logic [7:0] ram [0:65535];
  logic [7:0] rd_pipe [0:READ_LAT-1];

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
  end

  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[READ_LAT-1];

  // Reference model state
  logic [7:0] ref_mem [0:65535];
  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } ret_t;
  ret_t ret_q[$];

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic        av_prev      = 1'b1;
  int          wait_m       = 0;
  int          miss_m       = 0;
  logic [15:0] last_addr_m  = '0;
  logic        we_exp       = 1'b0;
  logic [7:0]  wdata_m      = '0;
  logic        m_g0, m_g1;
  logic        obs_g0, obs_g1, obs_p1_rvalid;
  logic [7:0]  obs_p1_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: inputs are already set; check at the falling edge,
  // advance the model, then move to just after the next rising edge.
  task automatic step();
    logic       g0, g1, p1_first, rv0, rv1;
    logic [7:0] rd;
    ret_t       r;
    @(negedge Clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (Reset_n) begin
      p1_first = (wait_m >= MAX_WAIT) || !av_prev;
      if (p1_first) begin
        g1 = p1_req;
        g0 = p0_req && !p1_req;
      end else begin
        g0 = p0_req;
        g1 = p1_req && !p0_req;
      end
    end
    check_eq("p0_gnt", p0_gnt, g0);
    check_eq("p1_gnt", p1_gnt, g1);

    rv0 = 1'b0;
    rv1 = 1'b0;
    rd  = '0;
    if (!Reset_n) begin
      ret_q.delete();
    end else if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r   = ret_q.pop_front();
      rv0 = !r.port;
      rv1 = r.port;
      rd  = r.data;
    end
    check_eq("p0_rvalid", p0_rvalid, rv0);
    check_eq("p1_rvalid", p1_rvalid, rv1);
    if (rv0) check_eq("p0_rdata", p0_rdata, rd);
    if (rv1) check_eq("p1_rdata", p1_rdata, rd);
    check_eq("mem_we", mem_we, we_exp);
    check_eq("mem_addr", mem_addr, last_addr_m);
    if (we_exp) check_eq("mem_wdata", mem_wdata, wdata_m);
    check_eq("p0_miss_cnt", p0_miss_cnt, miss_m);

    m_g0          = g0;
    m_g1          = g1;
    obs_g0        = p0_gnt;
    obs_g1        = p1_gnt;
    obs_p1_rvalid = p1_rvalid;
    obs_p1_rdata  = p1_rdata;

    if (!Reset_n) begin
      wait_m      = 0;
      av_prev     = 1'b1;
      miss_m      = 0;
      last_addr_m = '0;
      we_exp      = 1'b0;
      wdata_m     = '0;
    end else begin
      we_exp = g1 && p1_we;
      if (g0) begin
        last_addr_m = p0_addr;
        ret_q.push_back('{due: cyc + 1 + READ_LAT, port: 1'b0, data: ref_mem[p0_addr]});
      end else if (g1) begin
        last_addr_m = p1_addr;
        wdata_m     = p1_wdata;
        if (p1_we) ref_mem[p1_addr] = p1_wdata;
        else ret_q.push_back('{due: cyc + 1 + READ_LAT, port: 1'b1, data: ref_mem[p1_addr]});
      end
      if (p0_req && !g0 && miss_m < 65535) miss_m++;
      if (p1_req && !g1) wait_m = (wait_m + 1 > MAX_WAIT) ? MAX_WAIT : wait_m + 1;
      else wait_m = 0;
      av_prev = active_video;
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_random(input int n, input int p0_pct, input int p1_pct);
    logic p0_pend, p1_pend;
    p0_pend = 1'b0;
    p1_pend = 1'b0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(99) < 3) active_video = ~active_video;
      if (!p0_pend && $urandom_range(99) < p0_pct) begin
        p0_pend = 1'b1;
        p0_addr = 16'h1230 + 16'($urandom_range(15));
      end
      if (!p1_pend && $urandom_range(99) < p1_pct) begin
        p1_pend  = 1'b1;
        p1_we    = 1'($urandom_range(1));
        p1_addr  = 16'h1230 + 16'($urandom_range(15));
        p1_wdata = 8'($urandom);
      end
      p0_req = p0_pend;
      p1_req = p1_pend;
      step();
      if (m_g0) p0_pend = 1'b0;
      if (m_g1) p1_pend = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    $display("[TB] random phase %0d cycles p0 %0d%% p1 %0d%% done", n, p0_pct, p1_pct);
  endtask

  int         first_p1;
  logic       resumed;
  logic       found;
  logic [7:0] got_byte;
  int         stale_cnt;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    Reset_n      = 1'b0;
    active_video = 1'b1;
    p0_req       = 1'b0;
    p0_addr      = '0;
    p1_req       = 1'b0;
    p1_we        = 1'b0;
    p1_addr      = '0;
    p1_wdata     = '0;
    step();
    step();
    Reset_n = 1'b1;
    step();

    // T1: back-to-back port 0 reads in the visible region
    for (int i = 0; i < 4; i++) begin
      p0_req  = 1'b1;
      p0_addr = 16'h0010 + 16'(i);
      $display("[TB] T1 p0 read 0x%04h", p0_addr);
      step();
    end
    p0_req = 1'b0;
    repeat (5) step();

    // T2: both held in VIDEO, port 1 forced after MAX_WAIT
    p0_req   = 1'b1;
    p0_addr  = 16'h0030;
    p1_req   = 1'b1;
    p1_we    = 1'b0;
    p1_addr  = 16'h0020;
    first_p1 = 0;
    resumed  = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (obs_g1 && first_p1 == 0) first_p1 = k;
      if (first_p1 != 0 && k == first_p1 + 1) resumed = obs_g0;
    end
    check_eq("t2_force_cycle", first_p1, 65);
    check_eq("t2_p0_resume", resumed, 1);
    check_eq("t2_miss_cnt", p0_miss_cnt, 1);
    $display("[TB] T2 p1 forced on cycle %0d, p0_miss_cnt %0d", first_p1, p0_miss_cnt);
    p0_req       = 1'b0;
    p1_req       = 1'b0;
    active_video = 1'b0;
    step();
    step();

    // T3: blanking, port 1 write then read-back of the same address
    p0_req   = 1'b1;
    p0_addr  = 16'h0040;
    p1_req   = 1'b1;
    p1_we    = 1'b1;
    p1_addr  = 16'h1234;
    p1_wdata = 8'hA5;
    step();
    check_eq("t3_write_gnt", obs_g1, 1);
    $display("[TB] T3 p1 write 0x1234 <= 0xA5");
    p1_we = 1'b0;
    step();
    check_eq("t3_read_gnt", obs_g1, 1);
    p1_req   = 1'b0;
    found    = 1'b0;
    got_byte = '0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (obs_p1_rvalid) begin
        found    = 1'b1;
        got_byte = obs_p1_rdata;
      end
    end
    check_eq("t3_raw_data", got_byte, 8'hA5);
    $display("[TB] T3 p1 read 0x1234 -> 0x%02h", got_byte);
    p0_req = 1'b0;
    repeat (4) step();

    // T4: alternating single-port reads, returns must not cross over
    active_video = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        p0_req  = 1'b1;
        p1_req  = 1'b0;
        p0_addr = 16'h0100 + 16'(i);
        $display("[TB] T4 p0 read 0x%04h", p0_addr);
      end else begin
        p0_req  = 1'b0;
        p1_req  = 1'b1;
        p1_we   = 1'b0;
        p1_addr = 16'h0200 + 16'(i);
        $display("[TB] T4 p1 read 0x%04h", p1_addr);
      end
      step();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (5) step();

    // T5: reset with two port 1 reads in flight
    p1_req  = 1'b1;
    p1_we   = 1'b0;
    p1_addr = 16'h0300;
    step();
    p1_addr = 16'h0301;
    step();
    p1_req       = 1'b0;
    Reset_n      = 1'b0;
    active_video = 1'b0;
    step();
    Reset_n = 1'b1;
    check_eq("t5_mem_we", mem_we, 0);
    check_eq("t5_mem_addr", mem_addr, 0);
    check_eq("t5_mem_wdata", mem_wdata, 0);
    check_eq("t5_miss_cnt", p0_miss_cnt, 0);
    p0_req   = 1'b1;
    p0_addr  = 16'h0050;
    p1_req   = 1'b1;
    p1_we    = 1'b1;
    p1_addr  = 16'h0302;
    p1_wdata = 8'h3C;
    stale_cnt = 0;
    step();
    check_eq("t5_mode_video", obs_g0, 1);
    if (obs_p1_rvalid) stale_cnt++;
    p0_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (obs_p1_rvalid) stale_cnt++;
      if (m_g1) p1_req = 1'b0;
    end
    p1_req = 1'b0;
    check_eq("t5_no_stale_rvalid", stale_cnt, 0);
    $display("[TB] T5 reset with reads in flight, stale returns %0d", stale_cnt);

    // Randomised traffic
    run_random(1500, 95, 50);
    run_random(1500, 60, 60);

    // T6: port 0 starved in blanking until the miss counter saturates
    p0_req       = 1'b0;
    p1_req       = 1'b0;
    active_video = 1'b0;
    step();
    p0_req  = 1'b1;
    p0_addr = 16'h0060;
    p1_req  = 1'b1;
    p1_we   = 1'b0;
    for (int k = 0; k < 65600; k++) begin
      p1_addr = 16'($urandom_range(65535));
      step();
    end
    check_eq("t6_miss_sat", p0_miss_cnt, 16'hFFFF);
    $display("[TB] T6 p0_miss_cnt 0x%04h", p0_miss_cnt);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
